// File: rtl/beta_pkg.sv
// Shared Beta-core definitions for the interrupt controller and the control decoder.
package beta_pkg;

    // Interrupt controller dispatch state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ENTER   = 2'd2,
        HANDLER = 2'd3
    } irq_state_t;

    // PCSEL code the decoder uses to vector to the interrupt handler
    localparam logic [2:0]  IRQ_PCSEL = 3'b100;
    // Interrupt handler entry address
    localparam logic [31:0] XADR      = 32'h0000_0008;

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one async interrupt line.
//  clk, n_rst : clock, async active-low reset
//  src        : asynchronous request line
//  rise_c     : one-cycle pulse on a synchronised 0->1 transition (combinational decode of flops)
module irq_edge_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic src,
    output logic rise_c
);

    logic meta;
    logic sync;
    logic sync_d;

    // Synchroniser chain and delayed copy for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= src;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise_c = sync & ~sync_d;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller for the Beta core: latches source edges as pending, masks and
// prioritises them (lowest index wins), issues a one-cycle registered IRQ strobe and tracks
// the handler through PC[31] so only one interrupt is in service at a time.
//  clk, n_rst  : clock, async active-low reset
//  irq_src     : async rising-edge request lines
//  pc_super    : PC[31] of the current instruction (1 = supervisor)
//  mask_we     : enable-mask write strobe, mask_wdata is the new mask
//  irq         : IRQ strobe to the control decoder
//  irq_id      : index of the last dispatched source
//  pending     : raw pending bits
//  in_service  : dispatched interrupt has not yet returned
module irq_ctrl
    import beta_pkg::*;
#(
    parameter int unsigned N_SRC = 8,
    parameter int unsigned ID_W  = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             pc_super,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending,
    output logic             in_service
);

    irq_state_t       state;
    irq_state_t       state_next;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr;
    logic [ID_W-1:0]  winner;
    logic             dispatch;

    // Per-source synchroniser and edge detector
    for (genvar g = 0; g < int'(N_SRC); g++) begin : g_src
        irq_edge_sync u_sync (
            .clk    (clk),
            .n_rst  (n_rst),
            .src    (irq_src[g]),
            .rise_c (rise[g])
        );
    end

    assign eligible = pending & mask;

    // Priority encoder: descending scan so the lowest set index is assigned last
    always_comb begin
        winner = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Next-state logic; dispatch only from IDLE in user mode
    always_comb begin
        state_next = state;
        dispatch   = 1'b0;
        case (state)
            IDLE: begin
                if ((|eligible) && !pc_super) begin
                    state_next = REQ;
                    dispatch   = 1'b1;
                end
            end
            REQ:     state_next = ENTER;
            ENTER:   if (pc_super)  state_next = HANDLER;
            HANDLER: if (!pc_super) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign clr = dispatch ? (N_SRC'(1) << winner) : '0;

    // State, outputs, mask and pending registers; a new edge beats the dispatch clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            irq        <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
            mask       <= '0;
            pending    <= '0;
        end else begin
            state      <= state_next;
            irq        <= (state_next == REQ);
            in_service <= (state_next == ENTER) || (state_next == HANDLER);
            if (dispatch) begin
                irq_id <= winner;
            end
            if (mask_we) begin
                mask <= mask_wdata;
            end
            pending <= (pending & ~clr) | rise;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a cycle-by-cycle vector table for single and priority
// dispatch, plus hand sequences for reset, supervisor blocking, the clear/set race and
// mid-service reset.
module tb_irq_ctrl;

    logic       clk;
    logic       n_rst;
    logic [7:0] irq_src;
    logic       pc_super;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic       in_service;

    int checks;
    int errors;

    irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .irq_src    (irq_src),
        .pc_super   (pc_super),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq        (irq),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] src;
        logic       sup;
        logic       mwe;
        logic [7:0] mwd;
        logic       e_irq;
        logic [2:0] e_id;
        logic [7:0] e_pend;
        logic       e_ins;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_irq;
        int lat;
        checks = 0;
        errors = 0;

        // Single dispatch of source 2, then priority 1 before 5 with mask writes around the decision
        tbl[0]  = '{8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 3'd0, 8'h00, 1'b0};
        tbl[1]  = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
        tbl[2]  = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
        tbl[3]  = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h04, 1'b0};
        tbl[4]  = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h00, 1'b0};
        tbl[5]  = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 1'b1};
        tbl[6]  = '{8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 1'b1};
        tbl[7]  = '{8'h04, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 1'b1};
        tbl[8]  = '{8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[9]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[10] = '{8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[11] = '{8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[12] = '{8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h00, 1'b0};
        tbl[13] = '{8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 3'd2, 8'h22, 1'b0};
        tbl[14] = '{8'h22, 1'b0, 1'b1, 8'h00, 1'b1, 3'd1, 8'h20, 1'b0};
        tbl[15] = '{8'h22, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd1, 8'h20, 1'b1};
        tbl[16] = '{8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 8'h20, 1'b1};
        tbl[17] = '{8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 8'h20, 1'b0};
        tbl[18] = '{8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 8'h00, 1'b0};
        tbl[19] = '{8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 3'd5, 8'h00, 1'b1};
        tbl[20] = '{8'h22, 1'b1, 1'b0, 8'h00, 1'b0, 3'd5, 8'h00, 1'b1};
        tbl[21] = '{8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 3'd5, 8'h00, 1'b0};

        // Reset with all lines high, then release with everything masked
        n_rst      = 1'b0;
        irq_src    = 8'hFF;
        pc_super   = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        #12;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        step();
        n_rst = 1'b1;
        n_irq = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (irq) n_irq++;
        end
        chk("masked_pending", 32'(pending), 32'hFF);
        chk("masked_no_irq", 32'(n_irq), 32'd0);

        // Clean reset before the vector table
        n_rst   = 1'b0;
        irq_src = 8'h00;
        step();
        step();
        n_rst = 1'b1;
        step();

        for (int v = 0; v < 22; v++) begin
            irq_src    = tbl[v].src;
            pc_super   = tbl[v].sup;
            mask_we    = tbl[v].mwe;
            mask_wdata = tbl[v].mwd;
            step();
            chk($sformatf("v%0d_irq", v), 32'(irq), 32'(tbl[v].e_irq));
            chk($sformatf("v%0d_id", v), 32'(irq_id), 32'(tbl[v].e_id));
            chk($sformatf("v%0d_pending", v), 32'(pending), 32'(tbl[v].e_pend));
            chk($sformatf("v%0d_in_service", v), 32'(in_service), 32'(tbl[v].e_ins));
        end
        mask_we = 1'b0;

        // Supervisor code is never preempted
        pc_super = 1'b1;
        irq_src  = 8'h01;
        n_irq    = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (irq) n_irq++;
        end
        chk("super_no_irq", 32'(n_irq), 32'd0);
        chk("super_pending", 32'(pending), 32'h01);
        pc_super = 1'b0;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (irq) begin
                lat = i;
                break;
            end
        end
        chk("super_release_fires", 32'((lat >= 1) && (lat <= 2)), 32'd1);
        chk("super_release_id", 32'(irq_id), 32'd0);
        step();
        pc_super = 1'b1;
        step();
        pc_super = 1'b0;
        step();
        chk("super_return", 32'(in_service), 32'd0);

        // Clear/set race on source 3: re-edge pulse coincides with its dispatch
        pc_super = 1'b1;
        irq_src  = 8'h08;
        step();
        irq_src = 8'h00;
        for (int i = 0; i < 4; i++) step();
        chk("race_pending_held", 32'(pending), 32'h08);
        irq_src = 8'h08;
        step();
        step();
        pc_super = 1'b0;
        step();
        chk("race_irq", 32'(irq), 32'd1);
        chk("race_id", 32'(irq_id), 32'd3);
        chk("race_pending_kept", 32'(pending), 32'h08);
        step();
        pc_super = 1'b1;
        step();
        pc_super = 1'b0;
        step();
        chk("race_return", 32'(in_service), 32'd0);
        step();
        chk("race_reserve_irq", 32'(irq), 32'd1);
        chk("race_reserve_id", 32'(irq_id), 32'd3);
        chk("race_reserve_pending", 32'(pending), 32'h00);
        step();
        pc_super = 1'b1;
        step();
        pc_super = 1'b0;
        step();

        // Reset while in the handler with another source still pending
        irq_src = 8'h00;
        step();
        step();
        irq_src = 8'h88;
        step();
        step();
        step();
        chk("mid_pending", 32'(pending), 32'h88);
        step();
        chk("mid_irq", 32'(irq), 32'd1);
        chk("mid_id", 32'(irq_id), 32'd3);
        pc_super = 1'b1;
        step();
        step();
        chk("mid_in_handler", 32'(in_service), 32'd1);
        chk("mid_pending_left", 32'(pending), 32'h80);
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_in_service", 32'(in_service), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_id", 32'(irq_id), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        irq_src  = 8'h00;
        pc_super = 1'b0;
        step();
        step();
        n_rst = 1'b1;
        n_irq = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (irq || in_service) n_irq++;
        end
        chk("mid_rst_quiet", 32'(n_irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
